// File: rtl/psram_pkg.sv
// Shared types and constants for the PSRAM burst sequencer: widths, command
// and byte-enable encodings, sequencer state enum and the address-step helper.
package psram_pkg;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 16;

  localparam logic CMD_WRITE = 1'b0;
  localparam logic CMD_READ  = 1'b1;

  // Active-low byte enables, bit 0 is the low byte.
  localparam logic [1:0] BE_BOTH = 2'b00;
  localparam logic [1:0] BE_LOW  = 2'b10;
  localparam logic [1:0] BE_HIGH = 2'b01;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_PREP  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4
  } seq_state_t;

  // Word addresses wrap from the top of the array back to zero.
  function automatic logic [ADDR_W-1:0] next_word_addr(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/psram_rd_fifo.sv
// Read-return FIFO: synchronous, power-of-two depth, head word shown while
// not empty (zero when empty); push ignored when full, pop ignored when empty.
module psram_rd_fifo
  import psram_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              sysclk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge sysclk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/psram_burst_seq.sv
// Burst sequencer in front of the async PSRAM controller: splits bursts into
// single-word go/mem_idle transactions. Optional watchdog: PSRAM_SEQ_TIMEOUT_EN.
module psram_burst_seq
  import psram_pkg::*;
#(
  parameter int LEN_W       = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              sysclk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_cmd,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [1:0]        req_be_n,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_go,
  output logic              mem_command,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_wr,
  output logic [1:0]        mem_byte_en,
  input  logic              mem_idle,
  input  logic [DATA_W-1:0] mem_data_rd,
  output seq_state_t        dbg_state
);

  // Handshakes: a request or read word transfers on a rising edge where its
  // valid and ready are both high; wr_ready is a one-cycle consume strobe
  // raised only while wr_valid is high, and the word is taken on that edge.

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LEN_W:0] REM_ONE = (LEN_W + 1)'(1);

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [LEN_W:0]   rem_q;
  logic             accept;
  logic             launch;
  logic             word_done;
  logic             last_word;
  logic             rd_space;
  logic             timeout;
  logic             to_hit;
  logic             done_q;
  logic             err_q;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             fifo_full;
  logic             fifo_push;
  logic             fifo_pop;

  assign last_word = (rem_q == REM_ONE);
  assign rd_space  = ~fifo_full && (fifo_count < CNT_W'(FIFO_DEPTH));

  always_ff @(posedge sysclk) begin
    if (!reset_n) state <= ST_INIT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    launch    = 1'b0;
    word_done = 1'b0;
    timeout   = 1'b0;
    case (state)
      ST_INIT:  if (mem_idle) state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = ST_PREP;
        end
      end
      ST_PREP: begin
        if (mem_idle && ((mem_command == CMD_WRITE) ? wr_valid : rd_space)) begin
          launch    = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: if (!mem_idle) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (mem_idle) begin
          word_done = 1'b1;
          state_nxt = last_word ? ST_IDLE : ST_PREP;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
    // A stuck controller abandons the burst; a word completing on the limit wins.
    if (to_hit && (state_nxt == state)) begin
      timeout   = 1'b1;
      state_nxt = ST_INIT;
    end
  end

  always_comb begin
    req_ready = (state == ST_IDLE);
    wr_ready  = launch && (mem_command == CMD_WRITE);
    busy      = (state == ST_PREP) || (state == ST_ISSUE) || (state == ST_WAIT);
    fifo_push = word_done && (mem_command == CMD_READ);
    rd_valid  = ~fifo_empty;
    fifo_pop  = ~fifo_empty && rd_ready;
    done      = done_q;
    err       = err_q;
    dbg_state = state;
  end

  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      mem_go      <= 1'b0;
      mem_command <= 1'b0;
      mem_addr    <= '0;
      mem_data_wr <= '0;
      mem_byte_en <= '0;
      rem_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= word_done && last_word;
      if (accept) begin
        mem_command <= req_cmd;
        mem_addr    <= req_addr;
        mem_byte_en <= req_be_n;
        rem_q       <= {1'b0, req_len} + REM_ONE;
      end
      if (launch) begin
        mem_go <= 1'b1;
        if (mem_command == CMD_WRITE) mem_data_wr <= wr_data;
      end else if ((state == ST_ISSUE) && !mem_idle) begin
        mem_go <= 1'b0;
      end
      if (word_done) begin
        mem_addr <= next_word_addr(mem_addr);
        rem_q    <= rem_q - REM_ONE;
      end
      if (timeout) mem_go <= 1'b0;
    end
  end

`ifdef PSRAM_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;

  // Restarts on every state change so ISSUE and WAIT each get the full budget.
  always_ff @(posedge sysclk) begin
    if (!reset_n || (state_nxt != state)) to_cnt <= '0;
    else if ((state == ST_ISSUE) || (state == ST_WAIT)) to_cnt <= to_cnt + TO_W'(1);
  end

  assign to_hit = ((state == ST_ISSUE) || (state == ST_WAIT)) &&
                  (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge sysclk) begin
    if (!reset_n)     err_q <= 1'b0;
    else if (timeout) err_q <= 1'b1;
  end
`else
  assign to_hit = 1'b0;
  assign err_q  = 1'b0;
`endif

  psram_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_rd_fifo (
    .sysclk    (sysclk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (mem_data_rd),
    .pop       (fifo_pop),
    .head      (rd_data),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_psram_burst_seq.sv
// Self-checking bench for psram_burst_seq: reactive PSRAM controller model,
// write-stream and read-stream agents, and a burst-level reference model.
module tb_psram_burst_seq;
  import psram_pkg::*;

  localparam int LEN_W       = 8;
  localparam int FIFO_DEPTH  = 4;
  localparam int TIMEOUT_CYC = 64;
  localparam int TXN_W       = 1 + 2 + ADDR_W + DATA_W;

  logic              sysclk;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_cmd;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [1:0]        req_be_n;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              busy;
  logic              done;
  logic              err;
  logic              mem_go;
  logic              mem_command;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_wr;
  logic [1:0]        mem_byte_en;
  logic              mem_idle;
  logic [DATA_W-1:0] mem_data_rd;
  seq_state_t        dbg_state;

  psram_burst_seq #(
    .LEN_W       (LEN_W),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .sysclk      (sysclk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_cmd     (req_cmd),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .req_be_n    (req_be_n),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .mem_go      (mem_go),
    .mem_command (mem_command),
    .mem_addr    (mem_addr),
    .mem_data_wr (mem_data_wr),
    .mem_byte_en (mem_byte_en),
    .mem_idle    (mem_idle),
    .mem_data_rd (mem_data_rd),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [TXN_W-1:0]  txn_exp_q[$];
  logic [DATA_W-1:0] rd_exp_q[$];
  logic [DATA_W-1:0] wr_src_q[$];
  logic [DATA_W-1:0] psram_mem[int];
  logic [DATA_W-1:0] ref_mem[int];

  bit ctrl_start = 0;
  bit hang       = 0;
  bit rd_en      = 0;
  int rd_pct     = 100;
  int txn_cnt    = 0;
  int wr_pulses  = 0;
  int wr_consumed = 0;
  int gap_at     = -1;
  int gap_left   = 0;
  int done_cnt   = 0;
  int burst_txn_base = 0;
  int burst_words    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
    return a[15:0] ^ {a[22:16], 9'h0A5};
  endfunction

  function automatic logic [DATA_W-1:0] merge_be(input logic [DATA_W-1:0] old_w,
                                                 input logic [DATA_W-1:0] new_w,
                                                 input logic [1:0] be_n);
    logic [DATA_W-1:0] r;
    r = old_w;
    if (!be_n[0]) r[7:0]  = new_w[7:0];
    if (!be_n[1]) r[15:8] = new_w[15:8];
    return r;
  endfunction

  // ---------------- PSRAM controller model ----------------
  initial begin : ctrl_model
    logic [TXN_W-1:0]  got;
    logic [DATA_W-1:0] old_w;
    int a;
    mem_idle    = 1'b0;
    mem_data_rd = '0;
    wait (ctrl_start);
    @(negedge sysclk);
    mem_idle = 1'b1;
    forever begin
      @(negedge sysclk);
      if (reset_n && mem_go) begin
        got = {mem_command, mem_byte_en, mem_addr,
               (mem_command == CMD_WRITE) ? mem_data_wr : 16'h0};
        txn_cnt++;
        if (txn_exp_q.size() == 0) check("txn_spurious", txn_exp_q.size(), 1);
        else check("txn", got, txn_exp_q.pop_front());
        if (hang) begin
          while (mem_go === 1'b1) @(negedge sysclk);
        end else begin
          repeat ($urandom_range(0, 1)) @(negedge sysclk);
          mem_idle = 1'b0;
          repeat ($urandom_range(1, 4)) @(negedge sysclk);
          check("txn_hold", {mem_command, mem_byte_en, mem_addr,
                (mem_command == CMD_WRITE) ? mem_data_wr : 16'h0}, got);
          check("go_dropped", mem_go, 0);
          a = int'(got[DATA_W +: ADDR_W]);
          old_w = psram_mem.exists(a) ? psram_mem[a] : init_word(ADDR_W'(a));
          if (got[TXN_W-1] == CMD_WRITE)
            psram_mem[a] = merge_be(old_w, got[DATA_W-1:0], got[DATA_W+ADDR_W +: 2]);
          else
            mem_data_rd = old_w;
          mem_idle = 1'b1;
        end
      end
    end
  end

  // ---------------- write stream driver ----------------
  initial begin : wr_driver
    bit gap_cycle;
    wr_valid = 1'b0;
    wr_data  = '0;
    forever begin
      @(negedge sysclk);
      gap_cycle = 0;
      if (gap_left > 0) begin
        wr_valid  = 1'b0;
        gap_left--;
        gap_cycle = 1;
      end else if (wr_src_q.size() > 0) begin
        wr_valid = 1'b1;
        wr_data  = wr_src_q[0];
      end else begin
        wr_valid = 1'b0;
        wr_data  = 16'($urandom);
      end
      #4;
      if (gap_cycle && gap_left <= 2) check("gap_no_go", mem_go, 0);
      if (wr_ready) begin
        check("wr_ready_needs_valid", wr_valid, 1);
        wr_pulses++;
        if (wr_src_q.size() > 0) void'(wr_src_q.pop_front());
        wr_consumed++;
        if (wr_consumed == gap_at) gap_left = 5;
      end
    end
  end

  // ---------------- read stream consumer ----------------
  initial begin : rd_consumer
    rd_ready = 1'b0;
    forever begin
      @(negedge sysclk);
      rd_ready = rd_en && ($urandom_range(0, 99) < rd_pct);
      #4;
      if (rd_valid && rd_ready) begin
        if (rd_exp_q.size() == 0) check("rd_spurious", rd_exp_q.size(), 1);
        else check("rd_data", rd_data, rd_exp_q.pop_front());
      end
    end
  end

  // ---------------- done monitor ----------------
  initial begin : done_mon
    forever begin
      @(negedge sysclk);
      #4;
      if (done) begin
        done_cnt++;
        check("done_after_all_words", txn_cnt - burst_txn_base, burst_words);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  // Reference model: one burst expands into words at base+i (mod 2^23).
  task automatic issue_burst(input logic cmd, input logic [ADDR_W-1:0] addr,
                             input logic [LEN_W-1:0] len, input logic [1:0] be,
                             input bit pattern_data, input bit with_gap);
    int words;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] old_w;
    bit got_rdy;
    words = int'(len) + 1;
    @(negedge sysclk);
    burst_txn_base = txn_cnt;
    burst_words    = words;
    if (with_gap) gap_at = wr_consumed + 2;
    for (int i = 0; i < words; i++) begin
      a = addr + ADDR_W'(i);
      if (cmd == CMD_WRITE) begin
        d = pattern_data ? (16'hA000 + 16'(i)) : 16'($urandom);
        old_w = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
        ref_mem[int'(a)] = merge_be(old_w, d, be);
        wr_src_q.push_back(d);
        txn_exp_q.push_back({cmd, be, a, d});
      end else begin
        rd_exp_q.push_back(ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a));
        txn_exp_q.push_back({cmd, be, a, 16'h0});
      end
    end
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_addr  = addr;
    req_len   = len;
    req_be_n  = be;
    got_rdy   = 0;
    for (int n = 0; n < 200; n++) begin
      #4;
      got_rdy = req_ready;
      @(negedge sysclk);
      if (got_rdy) break;
    end
    req_valid = 1'b0;
    req_cmd   = 1'($urandom);
    req_addr  = ADDR_W'($urandom);
    req_len   = LEN_W'($urandom);
    req_be_n  = 2'($urandom);
    check("req_accept", got_rdy, 1);
  endtask

  task automatic wait_done(input int target);
    for (int n = 0; n < 3000 && done_cnt < target; n++) tick(1);
    check("done_count", done_cnt, target);
  endtask

  task automatic wait_rd_drain();
    for (int n = 0; n < 1000 && rd_exp_q.size() > 0; n++) tick(1);
    check("rd_drained", rd_exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int base_txn;
    int base_wr;
    logic cmd;
    logic [ADDR_W-1:0] addr;
    bit ready_seen;

    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_cmd   = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    req_be_n  = '0;
    tick(3);
    #4;
    check("rst_ctrl", {req_ready, wr_ready, rd_valid, busy, done, err}, 0);
    check("rst_mem", {mem_go, mem_command, mem_addr, mem_data_wr, mem_byte_en}, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_state", dbg_state, ST_INIT);
    @(negedge sysclk);
    reset_n = 1'b1;

    // Controller still in its config cycle: no requests accepted.
    for (int i = 0; i < 10; i++) begin
      tick(1);
      #4;
      check("init_no_ready", req_ready, 0);
    end
    ctrl_start = 1;
    ready_seen = 0;
    for (int i = 0; i < 10 && !ready_seen; i++) begin
      tick(1);
      #4;
      ready_seen = req_ready;
    end
    check("ready_after_idle", ready_seen, 1);
    rd_en = 1;

    // Patterned 4-word write.
    base_wr = wr_pulses;
    issue_burst(CMD_WRITE, 23'h000010, 8'd3, BE_BOTH, 1, 0);
    wait_done(1);
    check("wr1_txns", txn_cnt - burst_txn_base, 4);
    check("wr1_pulses", wr_pulses - base_wr, 4);
    check("wr1_idle_ready", req_ready, 1);

    // Read across the top of the address space.
    issue_burst(CMD_READ, 23'h7FFFFE, 8'd2, BE_BOTH, 0, 0);
    wait_done(2);
    wait_rd_drain();

    // Read back the patterned write.
    issue_burst(CMD_READ, 23'h000010, 8'd3, BE_BOTH, 0, 0);
    wait_done(3);
    wait_rd_drain();

    // Downstream stalled: only FIFO_DEPTH words may be fetched.
    rd_en = 0;
    tick(2);
    issue_burst(CMD_READ, 23'h000100, 8'd7, BE_BOTH, 0, 0);
    base_txn = burst_txn_base;
    tick(80);
    check("stall_fetched", txn_cnt - base_txn, FIFO_DEPTH);
    check("stall_go_low", mem_go, 0);
    check("stall_state", dbg_state, ST_PREP);
    check("stall_rd_valid", rd_valid, 1);
    check("stall_busy", busy, 1);
    rd_en = 1;
    wait_done(4);
    wait_rd_drain();
    check("stall_total", txn_cnt - base_txn, 8);

    // Write with the data stream withheld before word 2, low byte only.
    base_wr = wr_pulses;
    issue_burst(CMD_WRITE, 23'h000200, 8'd4, BE_LOW, 0, 1);
    wait_done(5);
    check("gap_txns", txn_cnt - burst_txn_base, 5);
    check("gap_pulses", wr_pulses - base_wr, 5);
    issue_burst(CMD_READ, 23'h000200, 8'd4, BE_BOTH, 0, 0);
    wait_done(6);
    wait_rd_drain();

    // Randomized bursts with random downstream throttling.
    for (int it = 0; it < 14; it++) begin
      cmd    = 1'($urandom);
      addr   = ($urandom_range(0, 3) == 0) ? (23'h7FFFFF - ADDR_W'($urandom_range(0, 3)))
                                           : ADDR_W'($urandom_range(0, 63));
      rd_pct = $urandom_range(30, 100);
      issue_burst(cmd, addr, LEN_W'($urandom_range(0, 9)), 2'($urandom),
                  0, (cmd == CMD_WRITE) && ($urandom_range(0, 2) == 0));
      wait_done(7 + it);
    end
    rd_pct = 100;
    wait_rd_drain();
    check("err_clear", err, 0);

`ifdef PSRAM_SEQ_TIMEOUT_EN
    // Controller never answers: watchdog must abandon the burst.
    hang = 1;
    issue_burst(CMD_READ, 23'h000300, 8'd0, BE_BOTH, 0, 0);
    ready_seen = 0;
    for (int i = 0; i < 20 && !ready_seen; i++) begin
      tick(1);
      ready_seen = mem_go;
    end
    check("to_go_seen", ready_seen, 1);
    tick(60);
    check("to_not_yet", {err, mem_go}, 2'b01);
    tick(10);
    check("to_err", err, 1);
    check("to_go_low", mem_go, 0);
    check("to_busy", busy, 0);
    check("to_no_done", done_cnt, 20);
    rd_exp_q.delete();
    hang = 0;
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(3);
    check("to_err_reset", err, 0);
`endif

    check("txn_left", txn_exp_q.size(), 0);
    check("wr_left", wr_src_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
